// File: rtl/pht_update_scheduler_if.sv
// rtl/pht_update_scheduler_if.sv - resolution and PHT port bundle for the PHT update scheduler
//
// Purpose: groups the resolved-branch enqueue handshake, the fetch lookup
// indication and the scheduler's PHT read/write port.
// Signals:
//   res_valid/res_index/res_taken/res_ready : resolved-branch enqueue handshake
//   lookup_valid                            : fetch owns the PHT port this cycle
//   pht_addr/pht_rd/pht_rdata               : PHT read (data returns one cycle after pht_rd)
//   pht_we/pht_wdata                        : PHT write
// Modports: master = resolution logic + PHT side, slave = scheduler.
interface pht_update_scheduler_if #(
  parameter int INDEX_W = 10
);
  logic               res_valid;
  logic [INDEX_W-1:0] res_index;
  logic               res_taken;
  logic               res_ready;
  logic               lookup_valid;
  logic [INDEX_W-1:0] pht_addr;
  logic               pht_rd;
  logic [1:0]         pht_rdata;
  logic               pht_we;
  logic [1:0]         pht_wdata;

  modport master (
    output res_valid, res_index, res_taken, lookup_valid, pht_rdata,
    input  res_ready, pht_addr, pht_rd, pht_we, pht_wdata
  );

  modport slave (
    input  res_valid, res_index, res_taken, lookup_valid, pht_rdata,
    output res_ready, pht_addr, pht_rd, pht_we, pht_wdata
  );
endinterface

// File: rtl/pht_update_scheduler.sv
// rtl/pht_update_scheduler.sv - queues branch outcomes and applies 2-bit counter RMW updates to the PHT
//
// Purpose: resolved branch outcomes are pushed into a small circular FIFO and
// applied one at a time as read / capture / write sequences on the single PHT
// port, only in cycles where fetch is not doing a lookup.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : enqueue handshake, lookup_valid, PHT read/write port
//   busy         : queue non-empty or an update in progress
//   drop_count   : saturating count of outcomes offered while the queue was full
module pht_update_scheduler #(
  parameter int INDEX_W = 10,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pht_update_scheduler_if.slave  bus,
  output logic                   busy,
  output logic [7:0]             drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] idx_mem_q [DEPTH];
  logic [INDEX_W-1:0] idx_mem_d [DEPTH];
  logic               tkn_mem_q [DEPTH];
  logic               tkn_mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         old_q, old_d;
  logic [7:0]         drop_q, drop_d;

  logic               push;
  logic               pop;
  logic               drive_rd;
  logic               drive_wr;
  logic               chg;
  logic [1:0]         new_val;
  logic [INDEX_W-1:0] head_index;
  logic               head_taken;

  assign head_index = idx_mem_q[head_q];
  assign head_taken = tkn_mem_q[head_q];

  // Ready looks only at the registered count: a pop this cycle does not
  // make room for an enqueue in the same cycle.
  assign bus.res_ready = (count_q != CNT_W'(DEPTH));
  assign push          = bus.res_valid && bus.res_ready;

  // Saturating counter update from the captured old value.
  always_comb begin
    new_val = old_q;
    chg     = 1'b0;
    if (head_taken && (old_q != 2'b11)) begin
      new_val = old_q + 2'd1;
      chg     = 1'b1;
    end else if (!head_taken && (old_q != 2'b00)) begin
      new_val = old_q - 2'd1;
      chg     = 1'b1;
    end
  end

  // FSM next state and port strobes.
  always_comb begin
    state_d  = state_q;
    drive_rd = 1'b0;
    drive_wr = 1'b0;
    pop      = 1'b0;
    old_d    = old_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = RD;
      end
      RD: begin
        if (!bus.lookup_valid) begin
          drive_rd = 1'b1;
          state_d  = CAP;
        end
      end
      CAP: begin
        // Never stalled, so rdata is always taken exactly one cycle after pht_rd.
        old_d   = bus.pht_rdata;
        state_d = WR;
      end
      WR: begin
        if (!bus.lookup_valid) begin
          drive_wr = 1'b1;
          pop      = 1'b1;
          // Count after this pop (a simultaneous push keeps it non-empty).
          if ((count_q == CNT_W'(1)) && !push) state_d = IDLE;
          else                                 state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pht_rd    = drive_rd;
  assign bus.pht_we    = drive_wr && chg;
  assign bus.pht_addr  = (drive_rd || drive_wr) ? head_index : '0;
  assign bus.pht_wdata = drive_wr ? new_val : 2'b00;

  // Queue and drop-counter next state.
  always_comb begin
    idx_mem_d = idx_mem_q;
    tkn_mem_d = tkn_mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    drop_d    = drop_q;
    if (push) begin
      idx_mem_d[tail_q] = bus.res_index;
      tkn_mem_d[tail_q] = bus.res_taken;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (bus.res_valid && !bus.res_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      old_q   <= 2'b00;
      drop_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_mem_q[i] <= '0;
        tkn_mem_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      old_q     <= old_d;
      drop_q    <= drop_d;
      idx_mem_q <= idx_mem_d;
      tkn_mem_q <= tkn_mem_d;
    end
  end

  assign busy       = (count_q != '0) || (state_q != IDLE);
  assign drop_count = drop_q;

endmodule
